// File: rtl/seq_rbs_sub.sv
// Multi-cycle ripple-borrow subtractor: C_CHUNK bits of a-b per clock, borrow
// carried across cycles in a register, result returned as {borrow, difference}.

module seq_rbs_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

module seq_rbs_sub #(
  parameter int C_WIDTH = 16,
  parameter int C_CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_WIDTH-1:0] din_a,
  input  logic [C_WIDTH-1:0] din_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH:0]   dout
);
  localparam int N  = C_WIDTH / C_CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               borrow_q, borrow_d;
  logic [C_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;

  logic [C_CHUNK-1:0] a_sl, b_sl, d_sl;
  logic [C_CHUNK:0]   bchain;

  assign a_sl      = a_q[k_q*C_CHUNK +: C_CHUNK];
  assign b_sl      = b_q[k_q*C_CHUNK +: C_CHUNK];
  assign bchain[0] = borrow_q;

  // One borrow cell per bit of the chunk; the chain length is C_CHUNK, not C_WIDTH.
  seq_rbs_sub_bit u_bit [C_CHUNK-1:0] (
    .a    (a_sl),
    .b    (b_sl),
    .bin  (bchain[C_CHUNK-1:0]),
    .d    (d_sl),
    .bout (bchain[C_CHUNK:1])
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = din_a;
          b_d      = din_b;
          borrow_d = 1'b0;
          k_d      = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        res_d[k_q*C_CHUNK +: C_CHUNK] = d_sl;
        borrow_d = bchain[C_CHUNK];
        k_d      = k_q + 1'b1;
        if (k_q == KW'(N - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
    end
  end

  // Outputs come from state and registers only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign dout      = {borrow_q, res_q};

endmodule

// File: tb/tb_seq_rbs_sub.sv
// Directed and random checks of seq_rbs_sub at C_CHUNK = 1, 4 and 16 (C_WIDTH = 16).

module tb_seq_rbs_sub;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_s  [3];
  logic        out_ready_s [3];
  logic        in_ready_s  [3];
  logic        out_valid_s [3];
  logic [15:0] din_a_s     [3];
  logic [15:0] din_b_s     [3];
  logic [16:0] dout_s      [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_rbs_sub #(.C_WIDTH(16), .C_CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .din_a(din_a_s[0]), .din_b(din_b_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .dout(dout_s[0]));
  seq_rbs_sub #(.C_WIDTH(16), .C_CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .din_a(din_a_s[1]), .din_b(din_b_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .dout(dout_s[1]));
  seq_rbs_sub #(.C_WIDTH(16), .C_CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .din_a(din_a_s[2]), .din_b(din_b_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .dout(dout_s[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nlat(input int i);
    case (i)
      0:       return 16;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
    return {(a < b), 16'(a - b)};
  endfunction

  // Accept one operand pair on instance i, check latency/result, then drain it.
  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                       input string tag);
    int lat;
    bit rdy_seen;
    chk({tag, "_acc_rdy"}, in_ready_s[i], 1);
    din_a_s[i] = a; din_b_s[i] = b; in_valid_s[i] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[i] = 1'b0;
    din_a_s[i] = ~a; din_b_s[i] = ~b;
    lat = 0; rdy_seen = 0;
    if (in_ready_s[i]) rdy_seen = 1;
    while (!out_valid_s[i] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready_s[i]) rdy_seen = 1;
    end
    chk({tag, "_lat"}, lat, nlat(i));
    chk({tag, "_dout"}, dout_s[i], ref_sub(a, b));
    chk({tag, "_busy"}, rdy_seen, 0);
    out_ready_s[i] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[i] = 1'b0;
    chk({tag, "_ov_drop"}, out_valid_s[i], 0);
    chk({tag, "_ir_back"}, in_ready_s[i], 1);
  endtask

  initial begin
    logic [16:0] exp;
    logic [15:0] ra, rb;
    int cyc, acc, ndone, last;
    logic [16:0] q[$];

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i] = 0; out_ready_s[i] = 0; din_a_s[i] = '0; din_b_s[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", in_ready_s[i], 1);
      chk("rst_out_valid", out_valid_s[i], 0);
      chk("rst_dout", dout_s[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and cross-chunk borrow cases on the 4-bit-chunk instance
    do_op(1, 16'h1234, 16'h0234, "basic");
    do_op(1, 16'h1000, 16'h0001, "xborrow");
    do_op(1, 16'h0000, 16'h0001, "underflow");
    do_op(1, 16'hFFFF, 16'hFFFF, "equal");
    do_op(0, 16'h0000, 16'h0001, "c1_underflow");
    do_op(2, 16'h8000, 16'h7FFF, "c16_msb");

    // Back-pressure in DONE with noisy inputs
    exp = ref_sub(16'hABCD, 16'h1234);
    din_a_s[1] = 16'hABCD; din_b_s[1] = 16'h1234; in_valid_s[1] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[1] = 1'b0;
    cyc = 0;
    while (!out_valid_s[1] && cyc < 64) begin @(posedge clk); #1; cyc++; end
    chk("bp_lat", cyc, 4);
    for (int c = 0; c < 5; c++) begin
      in_valid_s[1] = ~in_valid_s[1];
      din_a_s[1] = 16'($urandom); din_b_s[1] = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_dout", dout_s[1], exp);
      chk("bp_in_ready", in_ready_s[1], 0);
      chk("bp_out_valid", out_valid_s[1], 1);
    end
    in_valid_s[1] = 1'b0;
    out_ready_s[1] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[1] = 1'b0;
    chk("bp_ov_drop", out_valid_s[1], 0);
    chk("bp_ir_back", in_ready_s[1], 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_single", out_valid_s[1], 0);
    end

    // Reset after two CALC cycles discards the operation
    din_a_s[1] = 16'hFFFF; din_b_s[1] = 16'h0001; in_valid_s[1] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[1] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready_s[1], 1);
    chk("midrst_out_valid", out_valid_s[1], 0);
    chk("midrst_dout", dout_s[1], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_idle", out_valid_s[1], 0);
    do_op(1, 16'h0005, 16'h0007, "postrst");

    // Random sweep on every chunk size
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 1000; v++)
        do_op(i, 16'($urandom), 16'($urandom), "sweep");

    // Streaming with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin
      q.delete();
      cyc = 0; acc = 0; ndone = 0; last = -1;
      in_valid_s[i] = 1'b1; out_ready_s[i] = 1'b1;
      while (ndone < 20 && cyc < 2000) begin
        if (in_ready_s[i] && acc < 20) begin
          ra = 16'($urandom); rb = 16'($urandom);
          din_a_s[i] = ra; din_b_s[i] = rb;
          q.push_back(ref_sub(ra, rb));
          if (last >= 0) chk("stream_ii", cyc - last, nlat(i) + 2);
          last = cyc;
          acc++;
        end
        if (out_valid_s[i]) begin
          if (q.size() > 0) chk("stream_dout", dout_s[i], q.pop_front());
          else chk("stream_extra", 1, 0);
          ndone++;
        end
        @(posedge clk); #1;
        cyc++;
        if (acc == 20) in_valid_s[i] = 1'b0;
      end
      chk("stream_timeout", (cyc < 2000), 1);
      chk("stream_count", ndone, 20);
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0;
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_rbs_sub.md
# seq_rbs_sub

Multi-cycle ripple-borrow subtractor: accepts two unsigned C_WIDTH-bit operands over a valid/ready handshake and computes the difference C_CHUNK bits per clock. The borrow is carried between cycles in a register. The result is returned as a (C_WIDTH+1)-bit word of borrow plus difference, behind a second valid/ready handshake. It is the subtract-direction companion to the team's combinational ripple-carry adder, for datapaths that trade latency for a short borrow chain.

## Interface
- C_WIDTH, 16: operand width in bits; must be ≥ 1.
- C_CHUNK, 4: bits processed per cycle; must divide C_WIDTH exactly. N = C_WIDTH/C_CHUNK is the number of compute cycles.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands.
- din_a  input  C_WIDTH  minuend, unsigned.
- din_b  input  C_WIDTH  subtrahend, unsigned.
- out_valid  output  1  result available on dout.
- out_ready  input  1  downstream accepts result.
- dout  output  C_WIDTH+1  {borrow, difference}:
  - dout[C_WIDTH-1:0] = (din_a − din_b) mod 2^C_WIDTH.
  - dout[C_WIDTH] = 1 iff din_a < din_b.

## Operation
- The FSM has three states: IDLE, CALC, DONE. It resets to IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid&in_ready at an edge, register din_a and din_b into internal operand registers, clear the borrow register, set chunk index k=0, and go to CALC.
  - Inputs may change freely after the accept edge.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge computes the slice [k*C_CHUNK +: C_CHUNK] = a_slice − b_slice − borrow, writes it into the result register, updates borrow with the chunk's borrow-out, and increments k.
  - On the edge where k==N−1, go to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid=1 and dout shows the registered result, stable until the handshake.
  - On an out_valid&out_ready edge, go to IDLE.
  - in_ready stays 0 in DONE. A new operand cannot be accepted on the same edge as the result handshake.
- Borrow convention:
  - Per bit: d = a ^ b ^ bin, bout = (~a & b) | (~a & bin) | (b & bin).
  - The final borrow register value becomes dout[C_WIDTH].
- No overflow detection beyond the borrow; operands are unsigned only.
- rst_n low at any time, including mid-CALC or in DONE:
  - Immediately clear state to IDLE, and k, borrow, operand and result registers to 0.
  - The in-flight operation is discarded and never reported.

## Timing
- Reset values: in_ready=1, out_valid=0, dout=0.
- Latency: accept at edge E → out_valid rises after edge E+N, so dout is valid N cycles after acceptance.
- C_CHUNK=C_WIDTH gives N=1: one CALC cycle.
- Minimum initiation interval is N+2 cycles, counting accept, N CALC cycles, DONE with out_ready=1, and return to IDLE. This assumes out_ready is held high.
- All outputs are registered or decoded from state only; there is no combinational path from din_*, in_valid or out_ready to any output.
- dout must not change while out_valid=1. Between operations it holds the last result; its value is don't-care when out_valid=0, except after reset, when it is 0.

## Test plan
- Basic case, C_WIDTH=16, C_CHUNK=4: a=0x1234, b=0x0234 → dout=0x0_1000, out_valid exactly 4 cycles after accept, in_ready low for the whole operation.
- Cross-chunk borrow: a=0x1000, b=0x0001 → dout=0x0_0FFF. Then a=0x0000, b=0x0001 → dout=0x1_FFFF. Then a=b=0xFFFF → dout=0x0_0000.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and din_* → dout stays stable, in_ready stays 0, and exactly one result is delivered when out_ready rises. in_ready returns 1 on the following cycle.
- Reset mid-CALC: assert rst_n=0 after 2 CALC cycles → in_ready=1, out_valid=0, dout=0 immediately. A subsequent op a=0x0005, b=0x0007 returns 0x1_FFFE with no stale result.
- Parameter sweep: C_CHUNK ∈ {1, 4, 16} with C_WIDTH=16, 1000 random operand pairs each against the reference model {a<b, (a−b) mod 2^16}. Check latency is 16, 4 and 1 cycles respectively.
- Streaming: in_valid and out_ready held high for 20 operations → each result is correct and accept edges are spaced exactly N+2 cycles apart.
